// File: rtl/instruction_fetch_stage.sv
// Fetch stage: owns the PC, issues one imem read at a time and fills the
// IF/ID register, with a one-entry skid buffer for responses during stalls.
module instruction_fetch_stage #(
  parameter int               PC_W      = 8,
  parameter int               INSTR_W   = 16,
  parameter logic [PC_W-1:0]  RESET_PC  = '0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_stall,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [PC_W-1:0]      pc;
  logic [PC_W-1:0]      req_pc;
  logic                 drop;
  logic                 hold;
  logic                 skid_valid;
  logic [INSTR_W-1:0]   skid_instr;
  logic [PC_W-1:0]      skid_pc;
  logic                 can_issue;
  logic                 accept;
  logic                 resp;

  always_comb begin
    can_issue = !redirect_valid
              & !skid_valid
              & !(if_valid & id_stall)
              & ((state == IDLE) | imem_rvalid);
    // an unaccepted request stays up until taken or withdrawn by redirect
    imem_req  = rst_n & !redirect_valid & (can_issue | hold);
    imem_addr = pc;
    accept    = imem_req & imem_ready;
    resp      = (state == WAIT) & imem_rvalid
              & !drop & !redirect_valid;
    state_nxt = state;
    if (redirect_valid) begin
      if (imem_rvalid) state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = WAIT;
    end else if (imem_rvalid) begin
      state_nxt = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      req_pc     <= RESET_PC;
      drop       <= 1'b0;
      hold       <= 1'b0;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc    <= '0;
      if_valid   <= 1'b0;
      if_instr   <= NOP_INSTR;
      if_pc      <= '0;
    end else begin
      hold <= imem_req & !imem_ready;
      if (accept) begin
        pc     <= pc + PC_W'(1);
        req_pc <= pc;
      end
      if (redirect_valid) begin
        pc         <= redirect_pc;
        drop       <= (state == WAIT) & !imem_rvalid;
        skid_valid <= 1'b0;
        if_valid   <= 1'b0;
        if_instr   <= NOP_INSTR;
      end else begin
        if ((state == WAIT) & imem_rvalid) drop <= 1'b0;
        if (skid_valid & !id_stall) begin
          if_valid   <= 1'b1;
          if_instr   <= skid_instr;
          if_pc      <= skid_pc;
          skid_valid <= 1'b0;
        end else if (resp & (!if_valid | !id_stall)) begin
          if_valid <= 1'b1;
          if_instr <= imem_rdata;
          if_pc    <= req_pc;
        end else if (resp) begin
          skid_valid <= 1'b1;
          skid_instr <= imem_rdata;
          skid_pc    <= req_pc;
        end else if (if_valid & !id_stall) begin
          if_valid <= 1'b0;
          if_instr <= NOP_INSTR;
        end
      end
    end
  end

endmodule
